// File: rtl/simdive_op_scheduler.sv
// simdive_op_scheduler: round-robin front end sharing one
// fixed-latency SIMDive mul/div datapath between two requesters.
module simdive_op_scheduler #(
  parameter int N     = 16,
  parameter int LAT   = 4,
  parameter int DEPTH = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           req0_valid,
  output logic           req0_ready,
  input  logic           req0_mode,
  input  logic           req0_func,
  input  logic [N-1:0]   req0_a,
  input  logic [N-1:0]   req0_b,
  input  logic           req1_valid,
  output logic           req1_ready,
  input  logic           req1_mode,
  input  logic           req1_func,
  input  logic [N-1:0]   req1_a,
  input  logic [N-1:0]   req1_b,
  output logic           resp0_valid,
  input  logic           resp0_ready,
  output logic [2*N-1:0] resp0_data,
  output logic [1:0]     resp0_dz,
  output logic           resp1_valid,
  input  logic           resp1_ready,
  output logic [2*N-1:0] resp1_data,
  output logic [1:0]     resp1_dz,
  output logic           dp_valid,
  output logic           dp_mode,
  output logic           dp_func,
  output logic [N-1:0]   dp_a,
  output logic [N-1:0]   dp_b,
  input  logic           dp_out_valid,
  input  logic [2*N-1:0] dp_result,
  output logic           err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int OW = $clog2(DEPTH + LAT + 2) + 1;

  logic           last_grant;
  logic           iss_own;
  logic [1:0]     iss_dz;
  logic           tag_v  [LAT];
  logic           tag_o  [LAT];
  logic [1:0]     tag_dz [LAT];
  logic [2*N-1:0] mem_d  [2][DEPTH];
  logic [1:0]     mem_dz [2][DEPTH];
  logic [AW-1:0]  wptr   [2];
  logic [AW-1:0]  rptr   [2];
  logic [CW-1:0]  cnt    [2];
  logic           push_k [2];
  logic           wr_en  [2];
  logic           pop    [2];
  logic           full   [2];
  logic [OW-1:0]  occ0, occ1;
  logic           elig0, elig1;
  logic           grant0, grant1;
  logic           sel_mode, sel_func;
  logic [N-1:0]   sel_a, sel_b;
  logic [1:0]     win_dz;
  logic           hv, ho;
  logic [1:0]     hdz;

  // credits in use: FIFO entries plus ops issued or in the tag pipe
  always_comb begin
    occ0 = OW'(cnt[0]);
    occ1 = OW'(cnt[1]);
    if (dp_valid) begin
      if (iss_own) occ1 = occ1 + OW'(1);
      else         occ0 = occ0 + OW'(1);
    end
    for (int i = 0; i < LAT; i++) begin
      if (tag_v[i]) begin
        if (tag_o[i]) occ1 = occ1 + OW'(1);
        else          occ0 = occ0 + OW'(1);
      end
    end
  end

  assign elig0  = req0_valid && (occ0 < OW'(DEPTH));
  assign elig1  = req1_valid && (occ1 < OW'(DEPTH));
  assign grant0 = elig0 && (!elig1 || last_grant);
  assign grant1 = elig1 && (!elig0 || !last_grant);
  assign req0_ready = grant0;
  assign req1_ready = grant1;

  assign sel_mode = grant1 ? req1_mode : req0_mode;
  assign sel_func = grant1 ? req1_func : req0_func;
  assign sel_a    = grant1 ? req1_a    : req0_a;
  assign sel_b    = grant1 ? req1_b    : req0_b;

  // divide-by-zero flags of the winning op, per lane in SIMD mode
  always_comb begin
    win_dz = 2'b00;
    if (sel_func) begin
      if (sel_mode)
        win_dz = {sel_b[N-1:N/2] == '0, sel_b[N/2-1:0] == '0};
      else
        win_dz = {2{sel_b == '0}};
    end
  end

  // issue register: drives the datapath for one cycle per grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dp_valid   <= 1'b0;
      dp_mode    <= 1'b0;
      dp_func    <= 1'b0;
      dp_a       <= '0;
      dp_b       <= '0;
      iss_own    <= 1'b0;
      iss_dz     <= 2'b00;
      last_grant <= 1'b1;
    end else begin
      dp_valid <= grant0 | grant1;
      if (grant0 | grant1) begin
        dp_mode    <= sel_mode;
        dp_func    <= sel_func;
        dp_a       <= sel_a;
        dp_b       <= sel_b;
        iss_own    <= grant1;
        iss_dz     <= win_dz;
        last_grant <= grant1;
      end
    end
  end

  // tag pipe: head lines up with the datapath result strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++) begin
        tag_v[i]  <= 1'b0;
        tag_o[i]  <= 1'b0;
        tag_dz[i] <= 2'b00;
      end
    end else begin
      tag_v[0]  <= dp_valid;
      tag_o[0]  <= iss_own;
      tag_dz[0] <= iss_dz;
      for (int i = 1; i < LAT; i++) begin
        tag_v[i]  <= tag_v[i-1];
        tag_o[i]  <= tag_o[i-1];
        tag_dz[i] <= tag_dz[i-1];
      end
    end
  end

  assign hv  = tag_v[LAT-1];
  assign ho  = tag_o[LAT-1];
  assign hdz = tag_dz[LAT-1];

  assign resp0_valid = cnt[0] != '0;
  assign resp1_valid = cnt[1] != '0;
  assign resp0_data  = mem_d[0][rptr[0]];
  assign resp1_data  = mem_d[1][rptr[1]];
  assign resp0_dz    = mem_dz[0][rptr[0]];
  assign resp1_dz    = mem_dz[1][rptr[1]];

  // per-requester push/pop strobes
  always_comb begin
    push_k[0] = dp_out_valid && hv && !ho;
    push_k[1] = dp_out_valid && hv && ho;
    pop[0]    = resp0_valid && resp0_ready;
    pop[1]    = resp1_valid && resp1_ready;
    for (int k = 0; k < 2; k++) begin
      full[k]  = cnt[k] == CW'(DEPTH);
      wr_en[k] = push_k[k] && !full[k];
    end
  end

  // response FIFOs, one per requester
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        for (int d = 0; d < DEPTH; d++) begin
          mem_d[k][d]  <= '0;
          mem_dz[k][d] <= 2'b00;
        end
        wptr[k] <= '0;
        rptr[k] <= '0;
        cnt[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        if (wr_en[k]) begin
          mem_d[k][wptr[k]]  <= dp_result;
          mem_dz[k][wptr[k]] <= hdz;
          wptr[k] <= wptr[k] + 1'b1;
        end
        if (pop[k]) rptr[k] <= rptr[k] + 1'b1;
        cnt[k] <= cnt[k] + CW'(wr_en[k]) - CW'(pop[k]);
      end
    end
  end

  // sticky error: strobe/tag mismatch or push into a full FIFO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if ((dp_out_valid != hv) ||
                 (push_k[0] && full[0]) ||
                 (push_k[1] && full[1])) begin
      err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_simdive_op_scheduler.sv
// tb_simdive_op_scheduler: directed bench with a behavioural
// datapath returning {a,b} after LAT cycles and a scoreboard.
module tb_simdive_op_scheduler;
  localparam int N     = 16;
  localparam int LAT   = 4;
  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst_n;
  logic req0_valid, req0_ready, req0_mode, req0_func;
  logic [N-1:0] req0_a, req0_b;
  logic req1_valid, req1_ready, req1_mode, req1_func;
  logic [N-1:0] req1_a, req1_b;
  logic resp0_valid, resp0_ready;
  logic [2*N-1:0] resp0_data;
  logic [1:0] resp0_dz;
  logic resp1_valid, resp1_ready;
  logic [2*N-1:0] resp1_data;
  logic [1:0] resp1_dz;
  logic dp_valid, dp_mode, dp_func;
  logic [N-1:0] dp_a, dp_b;
  logic dp_out_valid;
  logic [2*N-1:0] dp_result;
  logic err;
  logic inj;

  logic [LAT-1:0] mv;
  logic [2*N-1:0] md [LAT];

  int tests = 0;
  int fails = 0;
  logic [33:0] q0[$];
  logic [33:0] q1[$];
  int glog[$];

  always #5 clk = ~clk;

  simdive_op_scheduler #(.N(N), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_mode(req0_mode), .req0_func(req0_func),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_mode(req1_mode), .req1_func(req1_func),
    .req1_a(req1_a), .req1_b(req1_b),
    .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
    .resp0_data(resp0_data), .resp0_dz(resp0_dz),
    .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
    .resp1_data(resp1_data), .resp1_dz(resp1_dz),
    .dp_valid(dp_valid), .dp_mode(dp_mode), .dp_func(dp_func),
    .dp_a(dp_a), .dp_b(dp_b),
    .dp_out_valid(dp_out_valid), .dp_result(dp_result),
    .err(err)
  );

  assign dp_out_valid = mv[LAT-1] | inj;
  assign dp_result    = md[LAT-1];

  // datapath stand-in: {a,b} comes back LAT cycles after dp_valid
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mv <= '0;
      for (int i = 0; i < LAT; i++) md[i] <= '0;
    end else begin
      mv    <= {mv[LAT-2:0], dp_valid};
      md[0] <= {dp_a, dp_b};
      for (int i = 1; i < LAT; i++) md[i] <= md[i-1];
    end
  end

  function automatic logic [1:0] dz_model(input logic mode,
                                          input logic func,
                                          input logic [15:0] b);
    if (!func) return 2'b00;
    if (!mode) return (b == 16'h0) ? 2'b11 : 2'b00;
    return {b[15:8] == 8'h0, b[7:0] == 8'h0};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: push on request handshake, compare on response pop
  always @(negedge clk) begin
    if (rst_n) begin
      chk("one_grant_per_cycle", {63'd0, req0_ready & req1_ready}, 0);
      if (req0_valid && req0_ready) begin
        q0.push_back({dz_model(req0_mode, req0_func, req0_b), req0_a, req0_b});
        glog.push_back(0);
      end
      if (req1_valid && req1_ready) begin
        q1.push_back({dz_model(req1_mode, req1_func, req1_b), req1_a, req1_b});
        glog.push_back(1);
      end
      if (resp0_valid && resp0_ready) begin
        chk("resp0_expected", {63'd0, q0.size() != 0}, 1);
        if (q0.size() != 0) begin
          logic [33:0] e0;
          e0 = q0.pop_front();
          chk("resp0_sb_data", resp0_data, e0[31:0]);
          chk("resp0_sb_dz", resp0_dz, e0[33:32]);
        end
      end
      if (resp1_valid && resp1_ready) begin
        chk("resp1_expected", {63'd0, q1.size() != 0}, 1);
        if (q1.size() != 0) begin
          logic [33:0] e1;
          e1 = q1.pop_front();
          chk("resp1_sb_data", resp1_data, e1[31:0]);
          chk("resp1_sb_dz", resp1_dz, e1[33:32]);
        end
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    inj = 1'b0;
    q0.delete();
    q1.delete();
    glog.delete();
    step(2);
    rst_n = 1'b1;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 100) begin
      step();
      n++;
    end
    chk(tag, q0.size() + q1.size(), 0);
  endtask

  task automatic one_op(input logic mode, input logic func,
                        input logic [15:0] a, input logic [15:0] b,
                        input logic [1:0] edz, input string tag);
    int n;
    req0_mode = mode;
    req0_func = func;
    req0_a = a;
    req0_b = b;
    req0_valid = 1'b1;
    #1;
    n = 0;
    while (!req0_ready && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_accept"}, req0_ready, 1);
    step();
    req0_valid = 1'b0;
    n = 0;
    while (!resp0_valid && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_resp_valid"}, resp0_valid, 1);
    chk({tag, "_dz"}, resp0_dz, edz);
    chk({tag, "_data"}, resp0_data, {a, b});
  endtask

  initial begin
    int i0, i1;
    bit r0, r1;
    int cyc;
    logic [2*N-1:0] held;

    rst_n = 1'b0;
    inj = 1'b0;
    req0_valid = 0; req0_mode = 0; req0_func = 0; req0_a = '0; req0_b = '0;
    req1_valid = 0; req1_mode = 0; req1_func = 0; req1_a = '0; req1_b = '0;
    resp0_ready = 1'b1;
    resp1_ready = 1'b1;
    step(2);
    chk("rst_dp", {dp_valid, dp_mode, dp_func, dp_a, dp_b}, 0);
    chk("rst_resp", {resp0_valid, resp1_valid, resp0_dz, resp1_dz}, 0);
    chk("rst_err", err, 0);
    chk("rst_ready", {req0_ready, req1_ready}, 0);

    // single op with exact latency
    do_reset();
    req0_mode = 0; req0_func = 0;
    req0_a = 16'h0005; req0_b = 16'h0003;
    req0_valid = 1'b1;
    #1;
    chk("t1_ready0", req0_ready, 1);
    chk("t1_ready1", req1_ready, 0);
    step();
    req0_valid = 1'b0;
    chk("t1_dp_valid", dp_valid, 1);
    chk("t1_dp_ops", {dp_mode, dp_func, dp_a, dp_b}, 34'h0_0005_0003);
    step();
    chk("t1_dp_valid_drop", dp_valid, 0);
    chk("t1_dp_a_hold", dp_a, 16'h0005);
    step(LAT - 1);
    chk("t1_resp_not_yet", resp0_valid, 0);
    step();
    chk("t1_resp_valid", resp0_valid, 1);
    chk("t1_resp_data", resp0_data, 32'h0005_0003);
    chk("t1_resp_dz", resp0_dz, 2'b00);
    drain("t1_drain");

    // contention: both requesters stream
    do_reset();
    i0 = 0; i1 = 0; cyc = 0;
    while ((i0 < 6 || i1 < 6) && cyc < 200) begin
      req0_valid = (i0 < 6);
      req0_mode = 0; req0_func = 0;
      req0_a = 16'h0100 + 16'(i0);
      req0_b = 16'h0200 + 16'(i0);
      req1_valid = (i1 < 6);
      req1_mode = 1; req1_func = 1;
      req1_a = 16'h1100 + 16'(i1);
      req1_b = 16'h2000 + 16'(i1);
      #1;
      r0 = req0_valid && req0_ready;
      r1 = req1_valid && req1_ready;
      step();
      if (r0) i0++;
      if (r1) i1++;
      cyc++;
    end
    req0_valid = 0;
    req1_valid = 0;
    chk("t2_issued0", i0, 6);
    chk("t2_issued1", i1, 6);
    chk("t2_glog_len", {63'd0, glog.size() >= 4}, 1);
    if (glog.size() >= 4) begin
      for (int j = 0; j < 4; j++)
        chk($sformatf("t2_grant%0d", j), glog[j], j % 2);
    end
    drain("t2_drain");

    // credit stall on requester 1
    do_reset();
    resp0_ready = 1'b1;
    resp1_ready = 1'b0;
    i0 = 0; i1 = 0;
    for (int c = 0; c < 20; c++) begin
      req0_valid = 1; req0_mode = 0; req0_func = 0;
      req0_a = 16'h0A00 + 16'(i0); req0_b = 16'h0001;
      req1_valid = 1; req1_mode = 0; req1_func = 0;
      req1_a = 16'h3300 + 16'(i1); req1_b = 16'h0044;
      #1;
      r0 = req0_ready;
      r1 = req1_ready;
      step();
      if (r0) i0++;
      if (r1) i1++;
    end
    chk("t3_req1_accepts", i1, DEPTH);
    chk("t3_req1_blocked", req1_ready, 0);
    chk("t3_req0_progress", {63'd0, i0 >= 4}, 1);
    chk("t3_resp1_valid", resp1_valid, 1);
    held = resp1_data;
    step();
    chk("t3_resp1_hold", resp1_data, held);
    req0_valid = 0;
    resp1_ready = 1'b1;
    cyc = 0;
    while (i1 < 4 && cyc < 40) begin
      req1_a = 16'h3300 + 16'(i1);
      #1;
      r1 = req1_ready;
      step();
      if (r1) i1++;
      cyc++;
    end
    req1_valid = 0;
    chk("t3_req1_resumed", i1, 4);
    drain("t3_drain");

    // divide-by-zero flags
    one_op(1'b1, 1'b1, 16'h1234, 16'h0300, 2'b01, "t4_simd_lo0");
    one_op(1'b0, 1'b1, 16'h00FF, 16'h0000, 2'b11, "t4_full_div0");
    one_op(1'b0, 1'b0, 16'h0077, 16'h0000, 2'b00, "t4_mul_b0");
    one_op(1'b1, 1'b1, 16'h4321, 16'h0003, 2'b10, "t4_simd_hi0");
    drain("t4_drain");

    // protocol error: stray result strobe
    chk("t5_err_clear", err, 0);
    inj = 1'b1;
    step();
    inj = 1'b0;
    chk("t5_err_set", err, 1);
    step(3);
    chk("t5_err_held", err, 1);
    rst_n = 1'b0;
    #1;
    chk("t5_err_reset", err, 0);
    step();
    rst_n = 1'b1;

    // reset with three ops in flight
    do_reset();
    req0_mode = 1; req0_func = 1; req0_a = 16'hBEEF; req0_b = 16'h0101;
    req1_mode = 0; req1_func = 1; req1_a = 16'h1234; req1_b = 16'h5678;
    i0 = 0;
    for (int c = 0; c < 3; c++) begin
      req0_valid = 1;
      req1_valid = 1;
      #1;
      if (req0_ready || req1_ready) i0++;
      step();
    end
    req0_valid = 0;
    req1_valid = 0;
    chk("t6_issued", i0, 3);
    step();
    rst_n = 1'b0;
    q0.delete();
    q1.delete();
    #1;
    chk("t6_dp", {dp_valid, dp_mode, dp_func, dp_a, dp_b}, 0);
    chk("t6_resp", {resp0_valid, resp1_valid, resp0_dz, resp1_dz}, 0);
    chk("t6_data0", resp0_data, 0);
    chk("t6_data1", resp1_data, 0);
    chk("t6_err", err, 0);
    chk("t6_ready", {req0_ready, req1_ready}, 0);
    step(3);
    rst_n = 1'b1;
    step(LAT + 2);
    chk("t6_fifo_empty", {resp0_valid, resp1_valid}, 0);
    chk("t6_no_err", err, 0);
    req0_valid = 1;
    req1_valid = 1;
    #1;
    chk("t6_first_grant", {req0_ready, req1_ready}, 2'b10);
    step();
    req0_valid = 0;
    req1_valid = 0;
    drain("t6_drain");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/simdive_op_scheduler.md
Name: simdive_op_scheduler

Overview:
- Shares one fixed-latency SIMDive hybrid multiplier-divider datapath between two requesters.
- Round-robin arbitration on a valid/ready request interface drives the datapath's mode and function controls and operands.
- An internal tag pipeline tracks which requester owns each in-flight operation.
- Results are steered into per-requester response FIFOs, and issue is credit-gated so no result can ever be dropped.

Parameters:
- N, 16, operand width. Upper lane is a[N-1:N/2], lower lane is a[N/2-1:0] in SIMD mode.
- LAT, 4, datapath latency in cycles from dp_valid to dp_out_valid, 1..8.
- DEPTH, 2, response FIFO entries per requester, power of two, >=2.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- reqK_valid  in  1  request K (K=0,1) presents an operation.
- reqK_ready  out  1  request K accepted this cycle when valid&ready.
- reqK_mode  in  1  0 = one NxN op, 1 = two N/2 SIMD lanes.
- reqK_func  in  1  0 = multiply, 1 = divide.
- reqK_a  in  N  operand A (dividend).
- reqK_b  in  N  operand B (divisor).
- respK_valid  out  1  head of response FIFO K valid.
- respK_ready  in  1  requester K pops head.
- respK_data  out  2N  result.
- respK_dz  out  2  divide-by-zero flags; [1] upper lane, [0] lower lane.
- dp_valid  out  1  operation issued to datapath this cycle.
- dp_mode  out  1  to datapath mode.
- dp_func  out  1  to datapath mode_func.
- dp_a  out  N  datapath operand A.
- dp_b  out  N  datapath operand B.
- dp_out_valid  in  1  datapath result strobe.
- dp_result  in  2N  datapath result.
- err  out  1  sticky protocol error.

Behaviour:
- Reset: all outputs 0. FIFOs empty, tag pipe cleared, err=0, last_grant=1 (requester 0 wins first contest). Reset mid-operation flushes everything; in-flight results are lost, and the datapath must be reset on the same rst_n.
- Eligibility: eligible_K = reqK_valid && (inflight_K + count_K < DEPTH).
  - inflight_K = tags for K in the pipe.
  - count_K = FIFO K occupancy.
- Arbitration: at most one grant per cycle.
  - Only one eligible: it wins.
  - Both eligible: the requester opposite last_grant wins.
  - last_grant updates only on a grant.
  - reqK_ready = grant_K, combinational from eligibility and last_grant, and independent of reqK_a/b.
- Issue: on a handshake edge, dp_mode/func/a/b are registered from the winner and dp_valid=1 for exactly the next cycle. With no handshake, dp_valid=0 and the dp_* operands hold their last value. Throughput is one op per cycle.
- Divide-by-zero:
  - Computed at issue and carried with the tag.
  - func=1, mode=0: both dz bits = (b==0).
  - func=1, mode=1: dz[1]=(b upper lane==0), dz[0]=(b lower lane==0).
  - func=0: dz=00.
  - The op is still issued and the datapath result is passed unchanged.
- Tag pipe: a LAT-stage shift register of {valid, owner, dz}, loaded on the same edge as the dp_* registers. Its head is aligned so it is valid in the same cycle dp_out_valid is expected, LAT cycles after dp_valid.
- Writeback: when dp_out_valid and the head tag are valid, push {dp_result, dz} into FIFO[owner] on that edge. respK_valid rises the following cycle.
  - Credit gating guarantees the FIFO is never full at push.
  - Simultaneous push and pop in one cycle are both honoured.
  - Pointers wrap modulo DEPTH.
- Response: respK_data/dz come from the FIFO head, stable while valid && !ready. The pop occurs on respK_valid && respK_ready.
- err: set and held until reset when either occurs:
  - dp_out_valid != head tag valid, or
  - a push targets a full FIFO (defensive check).
- Back-to-back ops from both requesters may complete interleaved; order is preserved per requester.

Test Plan:
- Single op: req0 mode=0 func=0 a=0x0005 b=0x0003. Bench datapath model returns {a,b} after LAT=4. Required: dp_valid one cycle after the handshake, resp0_data=0x00050003 at handshake+LAT+2, resp0_dz=00.
- Contention: both requests valid every cycle, responses always ready. Required: grants alternate 0,1,0,1 starting with 0, and each response carries its own {a,b}.
- Credit stall: resp1_ready=0, req1 streams. Required: exactly DEPTH=2 accepts, then req1_ready=0. Req0 continues unaffected. Raising resp1_ready restores req1 after the FIFO drains.
- Divide-by-zero: func=1 mode=1 b=0x0300. Required: dz=01. Func=1 mode=0 b=0 gives dz=11. Func=0 b=0 gives dz=00.
- Protocol error: bench pulses dp_out_valid with no op in flight. Required: err=1, held until rst_n low.
- Reset mid-flight: assert rst_n low with 3 ops in the pipe. Required: all outputs 0, FIFOs empty, and the next contest is granted to req0.
